// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory round-robin arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADR_W = 16;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned MAX_C = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } arb_state_t;

    // Priority-pointer width; kept at least one bit so the register always exists.
    function automatic int unsigned ptr_width(input int unsigned c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, modulo C.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned C  = 2,
    parameter int unsigned PW = ptr_width(C)
) (
    input  logic [C-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [C-1:0]  pick,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < C; k++) begin
            idx = PW'((32'(ptr) + k) % C);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory port between C cores with registered grants.
// Optional grant-hold for atomic sequences is compiled in with DMEM_ARB_HOLD_EN.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned C        = 2,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [C-1:0]            req_read,
    input  logic [C-1:0]            req_write,
    input  logic [C-1:0][ADR_W-1:0] req_adr,
    input  logic [C-1:0][DAT_W-1:0] req_wdat,
    input  logic [C-1:0]            req_lock,
    input  logic [DAT_W-1:0]        mem_rdat,
    output logic [ADR_W-1:0]        mem_adr,
    output logic [DAT_W-1:0]        mem_wdat,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [C-1:0]            grant,
    output logic [C-1:0]            ack,
    output logic [DAT_W-1:0]        rdat
);

    localparam int unsigned PW = ptr_width(C);

    arb_state_t    state_q, state_d;
    logic [C-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [C-1:0]  req_any;
    logic [C-1:0]  pick_req;
    logic [C-1:0]  pick;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] ptr_after_pick;
    logic          any_ack;
    logic          reselect;

    assign req_any  = req_read | req_write;
    // The current grantee's request is consumed this cycle, so it never re-wins.
    assign pick_req = req_any & ~grant_q;

    rr_pick #(
        .C  (C),
        .PW (PW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < C; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    assign ptr_after_pick = (pick_idx == PW'(C - 1)) ? '0 : pick_idx + PW'(1);

`ifdef DMEM_ARB_HOLD_EN
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       lock_g;

    assign lock_g = |(grant_q & req_lock);
`else
    logic unused_hold;

    assign unused_hold = ^{req_lock, 4'(MAX_HOLD)};
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        reselect = 1'b0;
`ifdef DMEM_ARB_HOLD_EN
        hold_cnt_d = hold_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                reselect = 1'b1;
            end
            ACCESS: begin
                reselect = 1'b1;
`ifdef DMEM_ARB_HOLD_EN
                if (MAX_HOLD > 1 && lock_g && any_ack) begin
                    reselect   = 1'b0;
                    state_d    = HOLD;
                    hold_cnt_d = 4'd1;
                end
`endif
            end
`ifdef DMEM_ARB_HOLD_EN
            HOLD: begin
                if (!lock_g || (any_ack && hold_cnt_q == 4'(MAX_HOLD - 1))) begin
                    reselect = 1'b1;
                end else if (any_ack) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (reselect) begin
`ifdef DMEM_ARB_HOLD_EN
            hold_cnt_d = '0;
`endif
            if (pick_valid) begin
                grant_d = pick;
                ptr_d   = ptr_after_pick;
                state_d = ACCESS;
            end else begin
                grant_d = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef DMEM_ARB_HOLD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // Async reset on grant_q drops every strobe below without waiting for an edge.
    assign grant     = grant_q;
    assign ack       = grant_q & req_any;
    assign any_ack   = |ack;
    assign mem_write = |(grant_q & req_write);
    assign mem_read  = |(grant_q & req_read) & ~mem_write;
    assign rdat      = mem_rdat;

    always_comb begin
        mem_adr  = '0;
        mem_wdat = '0;
        for (int unsigned i = 0; i < C; i++) begin
            mem_adr  = mem_adr | ({ADR_W{grant_q[i]}} & req_adr[i]);
            mem_wdat = mem_wdat | ({DAT_W{grant_q[i]}} & req_wdat[i]);
        end
    end

endmodule
